// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S transmit path.
// Used by audio_i2s_tx (optional counter macro: I2S_TX_UNDERRUN_CNT_EN).
package audio_pkg;

    localparam int AUDIO_W        = 16;
    localparam int I2S_FRAME_BITS = 32;
    localparam int BIT_CNT_W      = 5;

    localparam logic [BIT_CNT_W-1:0] SLOT_LOAD    = 5'd1;
    localparam logic [BIT_CNT_W-1:0] SLOT_R_FIRST = 5'd16;

    typedef logic [AUDIO_W-1:0]        sample_t;
    typedef logic [I2S_FRAME_BITS-1:0] frame_t;
    typedef logic [BIT_CNT_W-1:0]      bit_cnt_t;

    function automatic frame_t pack_frame(input sample_t l, input sample_t r);
        return {l, r};
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every BCLK_HALF clk cycles and flags each 1->0 toggle.
module i2s_bclk_gen #(
    parameter int unsigned BCLK_HALF = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic fall_ce
);

    logic [7:0] div_q, div_d;
    logic       bclk_q, bclk_d;
    logic       term_s;

    assign term_s  = (div_q == 8'(BCLK_HALF - 1));
    assign fall_ce = enable && term_s && bclk_q;
    assign bclk    = bclk_q;

    // Next divider count and bclk level
    always_comb begin
        div_d  = div_q;
        bclk_d = bclk_q;
        if (!enable) begin
            div_d  = 8'd0;
            bclk_d = 1'b0;
        end else if (term_s) begin
            div_d  = 8'd0;
            bclk_d = ~bclk_q;
        end else begin
            div_d  = div_q + 8'd1;
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 8'd0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo 16-bit I2S transmitter with a one-deep sample holding register.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_HALF        = 8,
    parameter int unsigned MUTE_ON_UNDERRUN = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    input  logic [AUDIO_W-1:0] in_l,
    input  logic [AUDIO_W-1:0] in_r,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_sdata,
    output logic               frame_ce,
    output logic               overrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_cnt
`endif
);

    logic     fall_ce_s;
    logic     load_s;
    bit_cnt_t bit_cnt_inc_s;

    bit_cnt_t bit_cnt_q, bit_cnt_d;
    logic     lrck_q, lrck_d;
    logic     sdata_q, sdata_d;
    frame_t   shreg_q, shreg_d;
    frame_t   hold_q, hold_d;
    frame_t   last_q, last_d;
    logic     pending_q, pending_d;
    logic     frame_ce_q, frame_ce_d;
    logic     overrun_q, overrun_d;

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .bclk    (i2s_bclk),
        .fall_ce (fall_ce_s)
    );

    assign bit_cnt_inc_s = bit_cnt_q + 5'd1;
    assign load_s        = fall_ce_s && (bit_cnt_inc_s == SLOT_LOAD);

    // Serializer, holding register and pulse generation
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        sdata_d    = sdata_q;
        shreg_d    = shreg_q;
        hold_d     = hold_q;
        last_d     = last_q;
        frame_ce_d = load_s;
        overrun_d  = in_valid && pending_q && !load_s;

        if (!enable) begin
            bit_cnt_d = 5'd0;
            lrck_d    = 1'b0;
            sdata_d   = 1'b0;
            shreg_d   = '0;
        end else if (fall_ce_s) begin
            bit_cnt_d = bit_cnt_inc_s;
            lrck_d    = (bit_cnt_inc_s >= SLOT_R_FIRST);
            if (!load_s) begin
                shreg_d = {shreg_q[I2S_FRAME_BITS-2:0], 1'b0};
            end else if (pending_q) begin
                shreg_d = hold_q;
                last_d  = hold_q;
            end else if (MUTE_ON_UNDERRUN != 0) begin
                shreg_d = '0;
            end else begin
                shreg_d = last_q;
            end
            sdata_d = shreg_d[I2S_FRAME_BITS-1];
        end else begin
            sdata_d = sdata_q;
        end

        // A load consumes the old holding value even when a new sample lands the same cycle
        if (in_valid) begin
            hold_d = pack_frame(in_l, in_r);
        end else begin
            hold_d = hold_q;
        end
        pending_d = load_s ? in_valid : (pending_q | in_valid);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q  <= 5'd0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            shreg_q    <= '0;
            hold_q     <= '0;
            last_q     <= '0;
            pending_q  <= 1'b0;
            frame_ce_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            sdata_q    <= sdata_d;
            shreg_q    <= shreg_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            frame_ce_q <= frame_ce_d;
            overrun_q  <= overrun_d;
        end
    end

    assign i2s_lrck  = lrck_q;
    assign i2s_sdata = sdata_q;
    assign frame_ce  = frame_ce_q;
    assign overrun   = overrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] unc_q, unc_d;

    // Saturating count of loads that found no fresh sample
    always_comb begin
        if (load_s && !pending_q && (unc_q != 16'hFFFF)) begin
            unc_d = unc_q + 16'd1;
        end else begin
            unc_d = unc_q;
        end
    end

    // Underrun counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            unc_q <= 16'd0;
        end else begin
            unc_q <= unc_d;
        end
    end

    assign underrun_cnt = unc_q;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: table phases, directed I2S sequences, random run.
module tb_audio_i2s_tx;

    localparam int BH   = 2;
    localparam int MUTE = 0;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid;
    logic [15:0] in_l, in_r;
    logic        i2s_bclk, i2s_lrck, i2s_sdata, frame_ce, overrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 clk = ~clk;

    audio_i2s_tx #(.BCLK_HALF(BH), .MUTE_ON_UNDERRUN(MUTE)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_l         (in_l),
        .in_r         (in_r),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .frame_ce     (frame_ce),
        .overrun      (overrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: position derived from count of enabled clks
    int          m_n = 0;
    logic [31:0] m_hold = '0, m_last = '0, m_word = '0;
    logic        m_pend = 1'b0, m_fce = 1'b0, m_ovr = 1'b0;
    int          m_unc = 0;

    int cyc = 0, fce_cnt = 0, ovr_cnt = 0, last_fce_cyc = 0, fce_gap = 0;
    logic prev_bclk = 1'b0;
    logic fell = 1'b0;

    typedef struct {
        int   cycles;
        logic rst;
        logic en;
        logic vld;
        int   exp_fce;
        int   exp_ovr;
    } row_t;
    row_t rows[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst_i, en_i, v_i, input logic [15:0] l_i, r_i);
        int   nn;
        logic ld;
        if (rst_i) begin
            m_n = 0; m_hold = '0; m_last = '0; m_word = '0;
            m_pend = 1'b0; m_fce = 1'b0; m_ovr = 1'b0; m_unc = 0;
        end else begin
            nn = m_n + 1;
            ld = en_i && (nn % (2*BH) == 0) && (((nn / (2*BH)) % 32) == 1);
            m_ovr = v_i && m_pend && !ld;
            if (ld) begin
                if (m_pend) begin
                    m_word = m_hold;
                    m_last = m_hold;
                end else begin
                    m_word = (MUTE != 0) ? 32'd0 : m_last;
                    if (m_unc < 65535) m_unc++;
                end
            end
            m_fce  = ld;
            m_pend = ld ? v_i : (m_pend | v_i);
            if (v_i) m_hold = {l_i, r_i};
            m_n = en_i ? nn : 0;
        end
    endtask

    task automatic tick(input logic rst_i, en_i, v_i, input logic [15:0] l_i, r_i);
        int f, b;
        logic e_sd;
        reset = rst_i; enable = en_i; in_valid = v_i; in_l = l_i; in_r = r_i;
        @(posedge clk);
        model_step(rst_i, en_i, v_i, l_i, r_i);
        #1;
        f = m_n / (2*BH);
        b = f % 32;
        e_sd = (f == 0) ? 1'b0 : m_word[31 - ((b + 31) % 32)];
        check("bclk",     i2s_bclk,  ((m_n / BH) % 2) == 1);
        check("lrck",     i2s_lrck,  (f != 0) && (b >= 16));
        check("sdata",    i2s_sdata, e_sd);
        check("frame_ce", frame_ce,  m_fce);
        check("overrun",  overrun,   m_ovr);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, m_unc);
`endif
        cyc++;
        if (frame_ce === 1'b1) begin
            fce_cnt++;
            fce_gap = cyc - last_fce_cyc;
            last_fce_cyc = cyc;
        end
        if (overrun === 1'b1) ovr_cnt++;
        fell = (prev_bclk === 1'b1) && (i2s_bclk === 1'b0);
        prev_bclk = i2s_bclk;
    endtask

    // Waits for the next load and collects slots 1..31 plus the following slot 0
    task automatic run_frame(output logic [31:0] cap, output logic lr15, output logic lr16);
        int guard = 0;
        int slots;
        cap = '0; lr15 = 1'bx; lr16 = 1'bx;
        tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
        while (frame_ce !== 1'b1 && guard < 400) begin
            tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
            guard++;
        end
        check("load_seen", frame_ce, 1'b1);
        cap   = {31'd0, i2s_sdata};
        slots = 1;
        while (slots < 32 && guard < 800) begin
            tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
            guard++;
            if (fell) begin
                cap = {cap[30:0], i2s_sdata};
                slots++;
                if (slots == 15) lr15 = i2s_lrck;
                if (slots == 16) lr16 = i2s_lrck;
            end
        end
        check("frame_complete", slots, 32);
    endtask

    initial begin
        logic [31:0] cap;
        logic        lr15, lr16;
        int          f0, o0, k;
        logic        en_r;

        rows[0] = '{cycles: 4,   rst: 1'b1, en: 1'b0, vld: 1'b0, exp_fce: 0, exp_ovr: 0};
        rows[1] = '{cycles: 100, rst: 1'b0, en: 1'b0, vld: 1'b0, exp_fce: 0, exp_ovr: 0};
        rows[2] = '{cycles: 5,   rst: 1'b0, en: 1'b0, vld: 1'b1, exp_fce: 0, exp_ovr: 4};
        rows[3] = '{cycles: 256, rst: 1'b0, en: 1'b1, vld: 1'b0, exp_fce: 2, exp_ovr: 0};
        rows[4] = '{cycles: 128, rst: 1'b0, en: 1'b1, vld: 1'b1, exp_fce: 1, exp_ovr: 126};

        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_l = 16'd0; in_r = 16'd0;

        for (int i = 0; i < 5; i++) begin
            f0 = fce_cnt; o0 = ovr_cnt;
            for (int c = 0; c < rows[i].cycles; c++)
                tick(rows[i].rst, rows[i].en, rows[i].vld, 16'($urandom), 16'($urandom));
            check($sformatf("row%0d_frame_ce", i), fce_cnt - f0, rows[i].exp_fce);
            check($sformatf("row%0d_overrun", i), ovr_cnt - o0, rows[i].exp_ovr);
            if (i == 3) check("frame_period", fce_gap, 64*BH);
        end

        // Known frame content, then underrun repeat
        tick(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
        check("reset_bclk",  i2s_bclk,  1'b0);
        check("reset_sdata", i2s_sdata, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 16'hA55A, 16'h1234);
        run_frame(cap, lr15, lr16);
        check("frame1_data", cap, 32'hA55A1234);
        check("frame1_lrck15", lr15, 1'b0);
        check("frame1_lrck16", lr16, 1'b1);
        run_frame(cap, lr15, lr16);
        check("frame2_repeat", cap, 32'hA55A1234);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_one", underrun_cnt, 16'd1);
`endif

        // Two samples between loads: one overrun, newest wins
        o0 = ovr_cnt;
        tick(1'b0, 1'b1, 1'b1, 16'h1111, 16'h0101);
        tick(1'b0, 1'b1, 1'b1, 16'h2222, 16'h0202);
        run_frame(cap, lr15, lr16);
        check("overrun_pulses", ovr_cnt - o0, 1);
        check("frame_after_overrun", cap, 32'h22220202);

        // Sample arriving on the load clk
        for (int i = 0; i < 2*BH - 1; i++) tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 1'b1, 16'h3333, 16'h0303);
        check("coincident_load", frame_ce, 1'b1);
        check("coincident_no_overrun", overrun, 1'b0);
        run_frame(cap, lr15, lr16);
        check("frame_after_coincident", cap, 32'h33330303);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_two", underrun_cnt, 16'd2);
`endif

        // Reset mid-frame at slot 9, then restart latency
        run_frame(cap, lr15, lr16);
        k = 1;
        while (k < 9) begin
            tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
            if (fell) k++;
        end
        tick(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
        check("midreset_outputs", {i2s_bclk, i2s_lrck, i2s_sdata, frame_ce, overrun}, 5'd0);
        tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        k = 0;
        do begin
            tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
            k++;
        end while (frame_ce !== 1'b1 && k < 200);
        check("restart_latency", k, 2*BH);

        // Random traffic with occasional disable and reset
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en_r = ~en_r;
            tick($urandom_range(0, 599) == 0, en_r, $urandom_range(0, 39) == 0,
                 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
